// File: rtl/twos_comp_serial.sv
// Bit-serial two's-complement engine: pass, negate, abs and ones-complement, LSB first over WIDTH cycles.
// Optional build macro TWOS_COMP_SAT_EN saturates overflowing negate/abs results to the maximum positive value.
module twos_comp_serial #(
    parameter int WIDTH = 12  // legal range 2..64
) (
    input  logic             t_clk,
    input  logic             t_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b01;
    localparam logic [1:0] MODE_ABS  = 2'b10;
    localparam logic [1:0] MODE_ONES = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic [WIDTH-1:0] res_r, res_s;
    logic [1:0]       mode_r, mode_s;
    logic             sign_r, sign_s;
    logic             seen_r, seen_s;
    logic             min_r, min_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             ovf_r, ovf_s;
    logic             zero_r, zero_s;
    logic [1:0]       step_s;
    logic             neg_eff_s;

    // One serial step: returns {seen_one_next, result_bit}.
    function automatic logic [1:0] serial_step(
        input logic [1:0] m,
        input logic       neg_eff,
        input logic       seen,
        input logic       in_bit
    );
        logic out_bit;
        logic seen_nxt;
        seen_nxt = seen;
        case (m)
            MODE_PASS: out_bit = in_bit;
            MODE_ONES: out_bit = ~in_bit;
            MODE_NEG, MODE_ABS: begin
                if (neg_eff) begin
                    out_bit  = seen ? ~in_bit : in_bit;
                    seen_nxt = seen | in_bit;
                end else begin
                    out_bit = in_bit;
                end
            end
            default: out_bit = in_bit;
        endcase
        return {seen_nxt, out_bit};
    endfunction

    // Next-state and datapath logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        res_s     = res_r;
        mode_s    = mode_r;
        sign_s    = sign_r;
        seen_s    = seen_r;
        min_s     = min_r;
        cnt_s     = cnt_r;
        ovf_s     = ovf_r;
        zero_s    = zero_r;
        neg_eff_s = (mode_r == MODE_NEG) || ((mode_r == MODE_ABS) && sign_r);
        step_s    = serial_step(mode_r, neg_eff_s, seen_r, shift_r[0]);

        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_s = x;
                    mode_s  = mode;
                    sign_s  = x[WIDTH-1];
                    min_s   = (x == MIN_NEG);
                    seen_s  = 1'b0;
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                shift_s = {1'b0, shift_r[WIDTH-1:1]};
                res_s   = {step_s[0], res_r[WIDTH-1:1]};
                seen_s  = step_s[1];
                if (cnt_r == LAST_CNT) begin
                    // Final bit: settle flags (and saturation) together with the last shift.
                    ovf_s = min_r & neg_eff_s;
`ifdef TWOS_COMP_SAT_EN
                    if (ovf_s) begin
                        res_s = MAX_POS;
                    end else begin
                        res_s = {step_s[0], res_r[WIDTH-1:1]};
                    end
`endif
                    zero_s  = (res_s == {WIDTH{1'b0}});
                    state_s = ST_DONE;
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge t_clk or negedge t_rst_n) begin
        if (!t_rst_n) begin
            state_r <= ST_IDLE;
            shift_r <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            mode_r  <= 2'b00;
            sign_r  <= 1'b0;
            seen_r  <= 1'b0;
            min_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            res_r   <= res_s;
            mode_r  <= mode_s;
            sign_r  <= sign_s;
            seen_r  <= seen_s;
            min_r   <= min_s;
            cnt_r   <= cnt_s;
            ovf_r   <= ovf_s;
            zero_r  <= zero_s;
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign o         = res_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_twos_comp_serial.sv
// Self-checking bench for twos_comp_serial (WIDTH = 12): vector table, corner sequences, random ops vs arithmetic model.
module tb_twos_comp_serial;

    localparam int W = 12;

    logic         t_clk = 1'b0;
    logic         t_rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [1:0]   mode = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] o;
    logic         ovf;
    logic         zero;

    int tests = 0;
    int failed = 0;

    twos_comp_serial #(.WIDTH(W)) dut (
        .t_clk(t_clk), .t_rst_n(t_rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .ovf(ovf), .zero(zero)
    );

    always #5 t_clk = ~t_clk;

`ifdef TWOS_COMP_SAT_EN
    localparam logic [W-1:0] MIN_RES = 12'h7FF;
`else
    localparam logic [W-1:0] MIN_RES = 12'h800;
`endif

    typedef struct packed {
        logic [1:0]   m;
        logic [W-1:0] xv;
        logic [W-1:0] eo;
        logic         eovf;
        logic         ezero;
    } vec_t;

    // Reference: arithmetic view of each mode.
    function automatic logic ref_ovf(input logic [W-1:0] xv, input logic [1:0] mv);
        logic neg;
        neg = (mv == 2'd1) || (mv == 2'd2 && xv[W-1]);
        return neg && (xv == 12'h800);
    endfunction

    function automatic logic [W-1:0] ref_o(input logic [W-1:0] xv, input logic [1:0] mv);
        int v;
        logic neg;
        logic [W-1:0] r;
        v   = int'(xv);
        neg = (mv == 2'd1) || (mv == 2'd2 && xv[W-1]);
        if (mv == 2'd3)   r = ~xv;
        else if (neg)     r = W'(-v);
        else              r = xv;
`ifdef TWOS_COMP_SAT_EN
        if (ref_ovf(xv, mv)) r = 12'h7FF;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] xv, input logic [1:0] mv, output int lat);
        x = xv; mode = mv; in_valid = 1'b1;
        @(posedge t_clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge t_clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge t_clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [W-1:0] xv, input logic [1:0] mv,
                             input logic [W-1:0] eo, input logic eovf, input logic ezero);
        int lat;
        launch(xv, mv, lat);
        chk({name, " latency"}, 64'(lat), 64'd12);
        chk({name, " o"}, 64'(o), 64'(eo));
        chk({name, " ovf"}, 64'(ovf), 64'(eovf));
        chk({name, " zero"}, 64'(zero), 64'(ezero));
        release_out();
        chk({name, " idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        vec_t vecs[10];
        int lat;
        logic [W-1:0] ho;
        logic hovf, hzero;
        logic [W-1:0] ops_x[4];
        logic [1:0]   ops_m[4];
        logic [W-1:0] expq[$];
        int acc[4];
        int n_acc, n_res, c;
        bit accepted;

        vecs[0] = '{2'b01, 12'h005, 12'hFFB, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 12'h800, MIN_RES, 1'b1, 1'b0};
        vecs[2] = '{2'b10, 12'h3A0, 12'h3A0, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 12'h0F0, 12'hF0F, 1'b0, 1'b0};
        vecs[4] = '{2'b01, 12'h000, 12'h000, 1'b0, 1'b1};
        vecs[5] = '{2'b00, 12'hA5C, 12'hA5C, 1'b0, 1'b0};
        vecs[6] = '{2'b10, 12'hFFF, 12'h001, 1'b0, 1'b0};
        vecs[7] = '{2'b01, 12'h800, MIN_RES, 1'b1, 1'b0};
        vecs[8] = '{2'b00, 12'h800, 12'h800, 1'b0, 1'b0};
        vecs[9] = '{2'b11, 12'hFFF, 12'h000, 1'b0, 1'b1};

        // Reset state
        #12;
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst o", 64'(o), 64'd0);
        chk("rst ovf", 64'(ovf), 64'd0);
        chk("rst zero", 64'(zero), 64'd0);
        t_rst_n = 1'b1;
        @(posedge t_clk); #1;

        for (int i = 0; i < 10; i++)
            run_check($sformatf("vec%0d", i), vecs[i].xv, vecs[i].m, vecs[i].eo, vecs[i].eovf, vecs[i].ezero);

        // Backpressure: hold DONE for 20 cycles while disturbing the inputs
        launch(12'h123, 2'b01, lat);
        chk("bp latency", 64'(lat), 64'd12);
        ho = o; hovf = ovf; hzero = zero;
        chk("bp o", 64'(o), 64'h EDD);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            x = W'($urandom);
            mode = 2'($urandom);
            @(posedge t_clk); #1;
            chk("bp hold o", 64'(o), 64'(ho));
            chk("bp hold flags", {62'd0, ovf, zero}, {62'd0, hovf, hzero});
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        release_out();
        chk("bp release in_ready", 64'(in_ready), 64'd1);
        chk("bp release out_valid", 64'(out_valid), 64'd0);
        run_check("after bp", 12'h0F0, 2'b11, 12'hF0F, 1'b0, 1'b0);

        // Reset mid-RUN with counter at 5
        x = 12'h2AA; mode = 2'b01; in_valid = 1'b1;
        @(posedge t_clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge t_clk);
        #1;
        t_rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk("midrst o", 64'(o), 64'd0);
        @(posedge t_clk); #1;
        t_rst_n = 1'b1;
        run_check("post rst", 12'h001, 2'b01, 12'hFFF, 1'b0, 1'b0);

        // Random operations against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] rx;
            logic [1:0] rm;
            rx = (i % 7 == 0) ? 12'h800 : W'($urandom);
            rm = 2'($urandom_range(0, 3));
            run_check($sformatf("rand%0d", i), rx, rm, ref_o(rx, rm), ref_ovf(rx, rm), ref_o(rx, rm) == '0);
        end

        // Back-to-back with in_valid and out_ready held high
        for (int i = 0; i < 4; i++) begin
            ops_x[i] = (i == 2) ? 12'h800 : W'($urandom);
            ops_m[i] = 2'($urandom_range(0, 3));
        end
        n_acc = 0; n_res = 0; c = 0;
        x = ops_x[0]; mode = ops_m[0]; in_valid = 1'b1; out_ready = 1'b1;
        while (n_res < 4 && c < 200) begin
            @(negedge t_clk);
            if (out_valid) begin
                if (expq.size() > 0) chk($sformatf("b2b res%0d", n_res), 64'(o), 64'(expq.pop_front()));
                else chk("b2b unexpected result", 64'd1, 64'd0);
                n_res++;
            end
            accepted = 1'b0;
            if (in_ready && in_valid) begin
                acc[n_acc] = c;
                expq.push_back(ref_o(x, mode));
                n_acc++;
                accepted = 1'b1;
            end
            @(posedge t_clk); #1;
            c++;
            if (accepted) begin
                if (n_acc < 4) begin
                    x = ops_x[n_acc]; mode = ops_m[n_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        chk("b2b results", 64'(n_res), 64'd4);
        chk("b2b accepts", 64'(n_acc), 64'd4);
        for (int i = 1; i < n_acc; i++)
            chk($sformatf("b2b interval%0d", i), 64'(acc[i] - acc[i-1]), 64'd14);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
